mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_pkg.sv | 30 +++
 rtl/load_extend.sv | 29 ++
 rtl/mem_access_unit.sv | 105 ++++++++++
 tb/tb_mem_access_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared state encoding, Funct3 encodings and lane helpers for the data-memory access path.
package mem_access_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  // Misalignment is judged on the size bits alone; the opcode check catches the rest.
  function automatic logic access_err(input logic rd, input logic wr,
                                      input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    mis = (f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00);
    if (rd) return mis || f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111;
    if (wr) return mis || f3 > F3_W;
    return 1'b0;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/halfword lane of a read word and sign- or zero-extends it.
// Purely combinational.
module load_extend
  import mem_access_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_rd,
  input  logic [1:0]        i_off,
  input  logic [2:0]        i_funct3,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] w_lane;

  assign w_lane = i_rd >> {i_off, 3'b000};

  always_comb begin
    o_data = w_lane;
    case (i_funct3)
      F3_B:    o_data = {{(DATA_W-8){w_lane[7]}}, w_lane[7:0]};
      F3_H:    o_data = {{(DATA_W-16){w_lane[15]}}, w_lane[15:0]};
      F3_BU:   o_data = {{(DATA_W-8){1'b0}}, w_lane[7:0]};
      F3_HU:   o_data = {{(DATA_W-16){1'b0}}, w_lane[15:0]};
      default: o_data = w_lane;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between EX/MEM and a synchronous data memory: load 3 cycles, store 2, error/no-op 1.
// req_ready only in IDLE; the response is a single-cycle pulse with no backpressure.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            Funct3,
  input  logic [DATA_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rdata,
  output logic                  err,
  output logic [DM_ADDRESS-1:0] dm_a,
  output logic [DATA_W-1:0]     dm_wd,
  output logic                  dm_re,
  output logic [3:0]            dm_we,
  input  logic [DATA_W-1:0]     dm_rd
);

  state_t                r_state;
  logic [DM_ADDRESS-1:0] r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [2:0]            r_funct3;
  logic                  r_mem_read;
  logic                  r_mem_write;
  logic [DATA_W-1:0]     r_rdata;
  logic                  r_err;

  logic                  w_acc_err;
  logic                  w_is_store;
  logic [DATA_W-1:0]     w_ext;
  logic                  w_unused_addr;

  assign w_acc_err     = access_err(MemRead, MemWrite, Funct3, addr[1:0]);
  assign w_is_store    = r_mem_write && !r_mem_read;
  assign w_unused_addr = ^addr[DATA_W-1:DM_ADDRESS];

  load_extend #(.DATA_W(DATA_W)) u_load_extend (
    .i_rd     (dm_rd),
    .i_off    (r_addr[1:0]),
    .i_funct3 (r_funct3),
    .o_data   (w_ext)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_funct3    <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_addr      <= addr[DM_ADDRESS-1:0];
            r_wdata     <= wdata;
            r_funct3    <= Funct3;
            r_mem_read  <= MemRead;
            r_mem_write <= MemWrite;
            r_err       <= w_acc_err;
            r_rdata     <= '0;
            r_state     <= (w_acc_err || !(MemRead || MemWrite)) ? RESP : ACCESS;
          end
        end
        ACCESS: r_state <= r_mem_read ? WAIT : RESP;
        WAIT: begin
          r_rdata <= w_ext;
          r_state <= RESP;
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Memory strobes decode straight off the state so an async reset kills them mid-cycle.
  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign dm_re     = (r_state == ACCESS) && r_mem_read;
  assign dm_we     = ((r_state == ACCESS) && w_is_store) ? byte_en(r_funct3, r_addr[1:0]) : 4'b0000;
  assign dm_a      = {r_addr[DM_ADDRESS-1:2], 2'b00};
  assign rdata     = r_rdata;
  assign err       = r_err;

  always_comb begin
    case (r_funct3[1:0])
      2'b00:   dm_wd = {4{r_wdata[7:0]}};
      2'b01:   dm_wd = {2{r_wdata[15:0]}};
      default: dm_wd = r_wdata;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomized load/store traffic against a byte-level memory reference model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [2:0]  Funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        err;
  logic [8:0]  dm_a;
  logic [31:0] dm_wd;
  logic        dm_re;
  logic [3:0]  dm_we;
  logic [31:0] dm_rd = 32'd0;

  logic        poke_en = 1'b0;
  logic [6:0]  poke_idx = 7'd0;
  logic [31:0] poke_val = 32'd0;
  logic [31:0] mem     [128];
  logic [31:0] ref_mem [128];

  int n_vec = 0;
  int n_miscmp = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Funct3    (Funct3),
    .addr      (addr),
    .wdata     (wdata),
    .rsp_valid (rsp_valid),
    .rdata     (rdata),
    .err       (err),
    .dm_a      (dm_a),
    .dm_wd     (dm_wd),
    .dm_re     (dm_re),
    .dm_we     (dm_we),
    .dm_rd     (dm_rd)
  );

  // Synchronous data memory seen by the DUT
  always @(posedge clk) begin
    if (poke_en) mem[poke_idx] <= poke_val;
    else
      for (int i = 0; i < 4; i++)
        if (dm_we[i]) mem[dm_a[8:2]][8*i +: 8] <= dm_wd[8*i +: 8];
    if (dm_re) dm_rd <= mem[dm_a[8:2]];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] val);
    @(negedge clk);
    poke_en  = 1'b1;
    poke_idx = 7'(idx);
    poke_val = val;
    ref_mem[idx] = val;
    @(posedge clk);
    #1 poke_en = 1'b0;
  endtask

  task automatic model(input logic [2:0] f3, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic exp_err, output int exp_lat,
                       output logic [31:0] exp_rdata, output logic [3:0] exp_be,
                       output logic [31:0] exp_wd);
    int size, off;
    logic [31:0] mask, v;
    bit load, store;
    load  = rd;
    store = wr && !rd;
    off   = int'(a[1:0]);
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    if (store && f3 > 3'd2) size = 0;
    if (!(load || store)) exp_err = 1'b0;
    else if (size == 0)   exp_err = 1'b1;
    else                  exp_err = (off % size) != 0;
    exp_lat   = (!(load || store) || exp_err) ? 1 : (load ? 3 : 2);
    exp_rdata = 32'd0;
    exp_be    = 4'd0;
    exp_wd    = 32'd0;
    if (load && !exp_err) begin
      v    = ref_mem[a[8:2]] >> (8 * off);
      mask = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 32'd1;
      v    = v & mask;
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
      exp_rdata = v;
    end
    if (store && !exp_err) begin
      for (int i = 0; i < 4; i++) begin
        exp_wd[8*i +: 8] = wd[8*(i % size) +: 8];
        if (i >= off && i < off + size) begin
          exp_be[i] = 1'b1;
          ref_mem[a[8:2]][8*i +: 8] = wd[8*(i - off) +: 8];
        end
      end
    end
  endtask

  task automatic run_req(input logic [2:0] f3, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd, input logic hold);
    logic        exp_err, e, busy_rdy;
    int          exp_lat, lat, re_cnt, we_cnt, w;
    logic [31:0] exp_rdata, exp_wd, wd_val, r;
    logic [3:0]  exp_be, we_val;
    logic [8:0]  a_val;
    model(f3, rd, wr, a, wd, exp_err, exp_lat, exp_rdata, exp_be, exp_wd);
    lat = 0; re_cnt = 0; we_cnt = 0; w = 0; busy_rdy = 1'b0;
    e = 1'b0; r = 32'd0; we_val = 4'd0; wd_val = 32'd0; a_val = 9'd0;
    @(negedge clk);
    check_eq("idle_rsp", 32'(rsp_valid), 32'd0);
    check_eq("idle_rdy", 32'(req_ready), 32'd1);
    Funct3 = f3; MemRead = rd; MemWrite = wr; addr = a; wdata = wd; req_valid = 1'b1;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1 if (!hold) req_valid = 1'b0;
    for (int c = 1; c <= 6 && lat == 0; c++) begin
      @(negedge clk);
      if (req_ready) busy_rdy = 1'b1;
      if (dm_re) begin re_cnt++; a_val = dm_a; end
      if (dm_we != 4'd0) begin we_cnt++; we_val = dm_we; wd_val = dm_wd; a_val = dm_a; end
      if (rsp_valid) begin lat = c; r = rdata; e = err; end
    end
    check_eq("latency", 32'(lat), 32'(exp_lat));
    check_eq("err", 32'(e), 32'(exp_err));
    check_eq("rdata", r, exp_rdata);
    check_eq("busy_rdy", 32'(busy_rdy), 32'd0);
    check_eq("dm_re_cnt", 32'(re_cnt), 32'((rd && !exp_err) ? 1 : 0));
    check_eq("dm_we_cnt", 32'(we_cnt), 32'((exp_be != 4'd0) ? 1 : 0));
    if (exp_be != 4'd0) begin
      check_eq("dm_we", 32'(we_val), 32'(exp_be));
      check_eq("dm_wd", wd_val, exp_wd);
    end
    if (re_cnt + we_cnt > 0) check_eq("dm_a", 32'(a_val), 32'({a[8:2], 2'b00}));
  endtask

  initial begin
    logic [2:0]  f3;
    logic [1:0]  sel;
    logic [31:0] a;
    int          n_rsp;

    for (int i = 0; i < 128; i++) poke(i, $urandom);
    check_eq("rst_rdy", 32'(req_ready), 32'd1);
    check_eq("rst_rsp", 32'(rsp_valid), 32'd0);
    check_eq("rst_re", 32'(dm_re), 32'd0);
    check_eq("rst_we", 32'(dm_we), 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    poke(0, 32'h80FF_1234);
    run_req(3'b000, 1'b1, 1'b0, 32'h0000_0003, 32'd0, 1'b0);         // LB
    poke(0, 32'h9ABC_0000);
    run_req(3'b101, 1'b1, 1'b0, 32'h0000_0002, 32'd0, 1'b0);         // LHU
    run_req(3'b000, 1'b0, 1'b1, 32'h0000_0005, 32'h0000_00A5, 1'b0); // SB
    run_req(3'b010, 1'b0, 1'b1, 32'h0000_0006, 32'h1234_5678, 1'b0); // SW misaligned
    run_req(3'b010, 1'b1, 1'b1, 32'h0000_0040, 32'hFFFF_FFFF, 1'b0); // read wins
    run_req(3'b010, 1'b0, 1'b0, 32'h0000_0044, 32'd0, 1'b0);         // no-op
    run_req(3'b011, 1'b1, 1'b0, 32'h0000_0048, 32'd0, 1'b0);         // illegal load
    run_req(3'b100, 1'b0, 1'b1, 32'h0000_0048, 32'd0, 1'b0);         // illegal store
    run_req(3'b001, 1'b0, 1'b1, 32'h0000_000A, 32'h0000_BEEF, 1'b0); // SH upper half
    run_req(3'b001, 1'b1, 1'b0, 32'h0000_000A, 32'd0, 1'b0);         // LH sign
    run_req(3'b010, 1'b1, 1'b0, 32'h0000_0008, 32'd0, 1'b1);         // back-to-back chain
    run_req(3'b001, 1'b0, 1'b1, 32'h0000_000E, 32'h0000_7A5C, 1'b1);
    run_req(3'b000, 1'b1, 1'b0, 32'h0000_000F, 32'd0, 1'b0);

    for (int n = 0; n < 400; n++) begin
      f3  = 3'($urandom_range(0, 7));
      sel = 2'($urandom_range(0, 3));
      a   = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      run_req(f3, sel[0], sel[1], a, $urandom, 1'($urandom_range(0, 3) == 0));
    end
    @(negedge clk);
    req_valid = 1'b0;

    // Reset while a word store is driving the memory
    @(negedge clk);
    Funct3 = 3'b010; MemRead = 1'b0; MemWrite = 1'b1;
    addr = 32'h0000_0020; wdata = 32'hDEAD_BEEF; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check_eq("rst_pre_we", 32'(dm_we), 32'hF);
    reset = 1'b0;
    #1;
    check_eq("rst_mid_we", 32'(dm_we), 32'd0);
    check_eq("rst_mid_rdy", 32'(req_ready), 32'd1);
    check_eq("rst_mid_rsp", 32'(rsp_valid), 32'd0);
    check_eq("rst_mid_err", 32'(err), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    n_rsp = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (rsp_valid) n_rsp++;
    end
    check_eq("rst_no_rsp", 32'(n_rsp), 32'd0);
    run_req(3'b010, 1'b1, 1'b0, 32'h0000_0020, 32'd0, 1'b0);         // store must not have landed

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
